// File: rtl/sw_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_input_conditioner_if
// Brief    : Raw board inputs and conditioned stopwatch control outputs
// Revision : 1.0
// ============================================================================
interface sw_input_conditioner_if;
    logic btn_pause;
    logic btn_reset;
    logic sw_adj;
    logic sw_sel;
    logic PAUSE;
    logic RESET;
    logic ADJ;
    logic SEL;

    // Board/stimulus side: drives raw pins, observes conditioned controls
    modport master (
        output btn_pause,
        output btn_reset,
        output sw_adj,
        output sw_sel,
        input  PAUSE,
        input  RESET,
        input  ADJ,
        input  SEL
    );

    // Conditioner side
    modport slave (
        input  btn_pause,
        input  btn_reset,
        input  sw_adj,
        input  sw_sel,
        output PAUSE,
        output RESET,
        output ADJ,
        output SEL
    );
endinterface
`default_nettype wire

// File: rtl/sw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sw_input_conditioner
// Brief    : Synchronise and debounce stopwatch buttons/switches into clean
//            pause level, reset pulse and adjust/select levels
// Revision : 1.0
// ============================================================================
module sw_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                    clk,
    input  logic                    RESET_N,
    sw_input_conditioner_if.slave   bus
);

    localparam int               c_num_ch   = 4;
    localparam int               c_ch_pause = 0;
    localparam int               c_ch_reset = 1;
    localparam int               c_ch_adj   = 2;
    localparam int               c_ch_sel   = 3;
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_num_ch-1:0] raw_in;
    logic [c_num_ch-1:0] s1_q;
    logic [c_num_ch-1:0] s1_d;
    logic [c_num_ch-1:0] s2_q;
    logic [c_num_ch-1:0] s2_d;
    logic [c_num_ch-1:0] stable_q;
    logic [c_num_ch-1:0] stable_d;
    logic [c_num_ch-1:0] press;
    logic [CNT_W-1:0]    cnt_q [c_num_ch];
    logic [CNT_W-1:0]    cnt_d [c_num_ch];
    logic                pause_q;
    logic                pause_d;
    logic                reset_q;
    logic                reset_d;

    assign raw_in = {bus.sw_sel, bus.sw_adj, bus.btn_reset, bus.btn_pause};

    always_comb begin
        s1_d     = raw_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        for (int i = 0; i < c_num_ch; i++) begin
            // Any cycle of agreement with the stable level restarts the count
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == c_cnt_max) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // Events come from the next stable value so outputs move on the same edge
        press   = stable_d & ~stable_q;
        reset_d = press[c_ch_reset];
        if (press[c_ch_reset]) begin
            pause_d = 1'b0;
        end else if (press[c_ch_pause]) begin
            pause_d = ~pause_q;
        end else begin
            pause_d = pause_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            pause_q  <= 1'b0;
            reset_q  <= 1'b0;
            for (int i = 0; i < c_num_ch; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            pause_q  <= pause_d;
            reset_q  <= reset_d;
            for (int i = 0; i < c_num_ch; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.PAUSE = pause_q;
    assign bus.RESET = reset_q;
    assign bus.ADJ   = stable_q[c_ch_adj];
    assign bus.SEL   = stable_q[c_ch_sel];

endmodule
`default_nettype wire

// File: doc/sw_input_conditioner.md
# sw_input_conditioner

Front-end conditioner for the stopwatch's user inputs. It takes raw, asynchronous, bouncing push-buttons and slide switches from the board and produces the clean, synchronous control signals the stopwatch core consumes:
- a toggling pause level
- a one-cycle reset pulse
- debounced adjust and select levels

It sits between the board I/O pins and the SW core, in the same clock domain as the core.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz); legal range ≥ 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES−1

- clk  in  1  system clock, all logic on rising edge
- RESET_N  in  1  reset, synchronous and active-low
- btn_pause  in  1  raw pause push-button, active-high, asynchronous
- btn_reset  in  1  raw reset push-button, active-high, asynchronous
- sw_adj  in  1  raw adjust slide switch, asynchronous
- sw_sel  in  1  raw select slide switch, asynchronous
- PAUSE  out  1  pause state level; 1 = paused
- RESET  out  1  one-cycle pulse on each debounced reset-button press
- ADJ  out  1  debounced sw_adj level
- SEL  out  1  debounced sw_sel level

## Operation
- There are four identical channels: pause, reset, adj, sel. Each channel has:
  - a 2-FF synchronizer, s1 → s2
  - a CNT_W-bit counter
  - a stable register
- Debounce rule, evaluated every cycle:
  - If s2 == stable, the counter is cleared to 0.
  - If s2 != stable and counter < DEBOUNCE_CYCLES−1, the counter increments.
  - If s2 != stable and counter == DEBOUNCE_CYCLES−1, then stable ← s2 and the counter is cleared.
- A single cycle of agreement with stable during counting restarts the count. Glitches shorter than DEBOUNCE_CYCLES cycles never reach the outputs.
- A channel's press event is true in the cycle its stable register transitions 0→1. Release (1→0) produces no event.
- PAUSE register:
  - reset-channel press: PAUSE ← 0 (stopwatch resumes running after a reset)
  - otherwise, pause-channel press: PAUSE ← ~PAUSE
  - otherwise: hold
- RESET register: it is high for exactly one cycle when the reset-channel press event is true. Holding the button produces one pulse only, and a new pulse requires a debounced release followed by another press.
- ADJ and SEL are the adj and sel stable registers, driven directly.
- Simultaneous debounced presses of pause and reset: reset wins. RESET pulses and PAUSE = 0.
- Inputs held high through reset deassertion are treated as fresh transitions. For example, sw_adj = 1 at reset exit gives ADJ = 1 after the normal latency, and btn_reset held gives one RESET pulse.

## Timing
- Reset (RESET_N = 0 at a rising edge) clears all synchronizer FFs, counters, stable registers and outputs on that edge: PAUSE = 0, RESET = 0, ADJ = 0, SEL = 0.
- Reset asserted mid-count discards the partial count. No output changes except clearing to 0.
- Latency: a raw input changes before edge 0 and is held.
  - s2 reflects it after edge 1.
  - stable, ADJ/SEL, RESET and the PAUSE toggle update at edge DEBOUNCE_CYCLES+1.
  - That is DEBOUNCE_CYCLES+2 edges after the first sampling edge.
- All outputs are registered with no combinational path from inputs. The RESET pulse width is exactly 1 clk period.
- The counter never exceeds DEBOUNCE_CYCLES−1, so there is no wrap-around.

## Test plan
Run with DEBOUNCE_CYCLES = 4 and CNT_W = 3.
- Reset: hold RESET_N = 0 for 3 cycles with all raw inputs = 1 → all outputs 0 during reset. After release, ADJ = SEL = 1 exactly 6 edges later, RESET pulses once for 1 cycle, and PAUSE = 0.
- Clean pause press: btn_pause 0→1 held for 10 cycles → PAUSE goes 0→1 at edge 6 and stays 1. Release and press again → PAUSE returns to 0. No RESET pulse occurs.
- Bounce rejection: btn_pause toggles 1,0,1,1,0,1 cycle-by-cycle, then holds 1 → PAUSE is unchanged until 4 consecutive synced-high cycles, then toggles exactly once.
- Reset priority: with PAUSE = 1, drive btn_pause and btn_reset high on the same cycle → RESET = 1 for one cycle, and PAUSE = 0 on that same edge, not toggled.
- Held reset button: btn_reset high for 50 cycles → exactly one RESET pulse, 1 cycle wide. A 3-cycle low glitch during the hold produces no second pulse.
- Reset mid-count: sw_sel rises, RESET_N = 0 at the 2nd count cycle, then released → SEL = 0 through reset, then rises 6 edges after the first post-reset sampling edge.
